dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port byte-addressed 16-bit data memory between two requesters: port A (multi-cycle core load/store) and port B (program loader / debug DMA). Performs 2-way round-robin arbitration, sequences exactly one memory read or write per grant, and returns a one-cycle acknowledge with read data. Sits between the requesters and the data memory's addr/dataIn/dataOut/MemRd/MemWr pins.

Parameters:
ADDR_W, 16, address width (byte address)
DATA_W, 16, data width (little-endian byte pair at addr, addr+1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
a_req  in  1  port A request; held high until a_ack
a_we  in  1  port A: 1 = write, 0 = read; stable while a_req
a_addr  in  ADDR_W  port A byte address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  port A one-cycle completion pulse
a_rdata  out  DATA_W  port A read data, valid while a_ack
a_err  out  1  port A error, valid while a_ack
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err  same as port A, for port B
mem_addr  out  ADDR_W  to memory addr
mem_din  out  DATA_W  to memory dataIn
mem_rd  out  1  to memory MemRd
mem_wr  out  1  to memory MemWr
mem_dout  in  DATA_W  from memory dataOut (registered in memory, valid the cycle after the mem_rd edge)
busy  out  1  high in any state except IDLE
last_grant  out  1  0 = A granted last, 1 = B granted last

Behaviour:
- Reset values: state IDLE, mem_rd/mem_wr 0, mem_addr/mem_din 0, all ack/err 0, rdata 0, busy 0, last_grant 1 (A wins first contention).
- FSM: IDLE -> ACCESS -> RESP -> IDLE. All mem_* outputs are registered.
- IDLE: if any req at a rising edge, select the winner, latch its we/addr/wdata into mem_addr/mem_din, set mem_rd = ~we or mem_wr = we, update last_grant, go to ACCESS.
- Arbitration: a single requester wins. When both request, the winner is the port not equal to last_grant (strict alternation).
- ACCESS: one cycle; memory samples mem_rd/mem_wr at its closing edge. At that edge, clear mem_rd/mem_wr and go to RESP.
- RESP: one cycle; ack of the granted port high; rdata = mem_dout for reads, 0 for writes; err = 0. Then go to IDLE.
- mem_rd and mem_wr are never high together. Each is high for exactly one cycle per grant.
- Latency: request sampled at edge N; ack high in the cycle after edge N+2. One access per 3 cycles minimum.
- Requester rules: drop req on the edge that samples ack, otherwise the request is re-issued. Changes to addr/we/wdata after the grant edge are ignored.
- The losing requester keeps req high and is served on the next IDLE.
- Address arithmetic is passthrough. Memory handles addr+1 wrap.
- Reset mid-operation: immediate return to IDLE with mem_wr forced 0. A write is committed only if its ACCESS closing edge occurred before reset asserted. No ack is issued for an aborted transfer.

Optional Feature:
Macro DMEM_ALIGN_CHECK_EN.
- Defined: a granted request with odd address bit 0 skips memory entirely (IDLE -> RESP, mem_rd/mem_wr stay 0), then pulses ack with err = 1 and rdata = 0. Latency is 2 edges.
- Undefined: odd addresses are accessed normally. a_err/b_err ports remain and are tied 0.

Decomposition:
- Package dmem_ctrl_pkg holds: FSM state encoding (IDLE, ACCESS, RESP), grant id constants GNT_A = 0 and GNT_B = 1, default ADDR_W/DATA_W.
- One sub-module: rr_arb2, a 2-way round-robin winner select from (a_req, b_req, last_grant). It is combinational and is instantiated once.

Test Plan:
- Memory preloaded with [0]=7, [1]=8. A reads addr 0 -> mem_rd one cycle, a_ack 3 edges after request, a_rdata = 0x0807, b_ack stays 0.
- B writes 0xBEEF to addr 20, then A reads addr 20 -> mem_wr one cycle with mem_din = 0xBEEF, then a_rdata = 0xBEEF.
- A and B both request from IDLE after reset -> A granted first (last_grant becomes 0), then B (last_grant 1). Both held continuously -> grants alternate A, B, A, B. mem_rd and mem_wr never both high.
- Reset asserted during ACCESS of a B write of 0x1234 to addr 4 (preload 11) -> mem_wr drops immediately, no b_ack, addr 4 still reads 0x000B (byte 5 = 0).
- Odd address: A reads addr 17 (preload [17]=7, [18]=32). Without macro -> a_rdata = 0x2007, a_err = 0. With DMEM_ALIGN_CHECK_EN -> no mem_rd, a_ack 2 edges after request, a_err = 1, a_rdata = 0.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// grant identifiers and default bus widths.
package dmem_ctrl_pkg;

    localparam int unsigned DMEM_ADDR_W = 16;
    localparam int unsigned DMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_e;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin winner select; a lone requester always wins, and on
// contention the port that did not win last time is chosen.
module rr_arb2
    import dmem_ctrl_pkg::*;
(
    input  logic a_req_i,
    input  logic b_req_i,
    input  logic last_grant_i,
    output logic valid_c_o,
    output logic gnt_c_o
);

    always_comb begin
        valid_c_o = a_req_i | b_req_i;
        gnt_c_o   = GNT_A;
        if (a_req_i && b_req_i) begin
            gnt_c_o = ~last_grant_i;
        end else if (b_req_i) begin
            gnt_c_o = GNT_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between core (A) and loader (B).
// Build option DMEM_ALIGN_CHECK_EN: odd addresses bypass memory and ack with err.
module dmem_arbiter
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              last_grant
);

    dmem_state_e       state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic              a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic              arb_valid_c, arb_gnt_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic [DATA_W-1:0] resp_data_c;

    // A port still holds req on the edge that samples its ack; mask it there.
    rr_arb2 u_rr_arb2 (
        .a_req_i      (a_req & ~a_ack_q),
        .b_req_i      (b_req & ~b_ack_q),
        .last_grant_i (last_grant_q),
        .valid_c_o    (arb_valid_c),
        .gnt_c_o      (arb_gnt_c)
    );

    assign sel_we_c    = (arb_gnt_c == GNT_B) ? b_we    : a_we;
    assign sel_addr_c  = (arb_gnt_c == GNT_B) ? b_addr  : a_addr;
    assign sel_wdata_c = (arb_gnt_c == GNT_B) ? b_wdata : a_wdata;
    assign resp_data_c = (we_q || err_q) ? '0 : mem_dout;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_err_d      = 1'b0;
        b_err_d      = 1'b0;
        a_rdata_d    = '0;
        b_rdata_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid_c) begin
                    gnt_d        = arb_gnt_c;
                    last_grant_d = arb_gnt_c;
                    we_d         = sel_we_c;
                    mem_addr_d   = sel_addr_c;
                    mem_din_d    = sel_wdata_c;
                    err_d        = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
                    if (sel_addr_c[0]) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        mem_rd_d = ~sel_we_c;
                        mem_wr_d = sel_we_c;
                        state_d  = ST_ACCESS;
                    end
`else
                    mem_rd_d = ~sel_we_c;
                    mem_wr_d = sel_we_c;
                    state_d  = ST_ACCESS;
`endif
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            // Memory read data is valid throughout RESP; capture it with the ack.
            ST_RESP: begin
                state_d = ST_IDLE;
                if (gnt_q == GNT_B) begin
                    b_ack_d   = 1'b1;
                    b_rdata_d = resp_data_c;
                    b_err_d   = err_q;
                end else begin
                    a_ack_d   = 1'b1;
                    a_rdata_d = resp_data_c;
                    a_err_d   = err_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_B;
            gnt_q        <= GNT_A;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_err_q      <= a_err_d;
            b_err_q      <= b_err_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign a_ack      = a_ack_q;
    assign a_rdata    = a_rdata_q;
    assign a_err      = a_err_q;
    assign b_ack      = b_ack_q;
    assign b_rdata    = b_rdata_q;
    assign b_err      = b_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-wide memory model
// whose read data is registered on the MemRd edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] mem_addr, mem_din, mem_dout;
    logic        mem_rd, mem_wr, busy, last_grant;

    logic [7:0]  mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_addr, pre_data;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, a_ack_cnt = 0, b_ack_cnt = 0;

    dmem_arbiter u_dut (
        .clk        (clk),
        .reset      (reset),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_ack      (a_ack),
        .a_rdata    (a_rdata),
        .a_err      (a_err),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_ack      (b_ack),
        .b_rdata    (b_rdata),
        .b_err      (b_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: little-endian byte pair, registered read, bench preload port.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_wr) begin
            mem[mem_addr[7:0]]         <= mem_din[7:0];
            mem[mem_addr[7:0] + 8'd1]  <= mem_din[15:8];
        end
        if (mem_rd) mem_dout <= {mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
    end

    always @(negedge clk) begin
        if (mem_rd) rd_cnt++;
        if (mem_wr) wr_cnt++;
        if (mem_rd && mem_wr) overlap_cnt++;
        if (a_ack) a_ack_cnt++;
        if (b_ack) b_ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // One transfer; lat counts edges from the request-sampling edge to ack visibility.
    task automatic xfer(input logic port, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata,
                        output logic err, output int lat);
        logic got;
        got = 1'b0; lat = 0; rdata = '0; err = 1'b0;
        @(negedge clk);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (port ? b_ack : a_ack) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        rdata = port ? b_rdata : a_rdata;
        err   = port ? b_err : a_err;
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        check("no_regrant", 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat, rd0, wr0, a0, b0, nack;
    logic        ord [0:3];
    logic [15:0] odat [0:3];

    initial begin
        reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        preload(8'd0, 8'd7);   preload(8'd1, 8'd8);
        preload(8'd4, 8'd11);  preload(8'd5, 8'd0);
        preload(8'd17, 8'd7);  preload(8'd18, 8'd32);
        @(negedge clk); reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last_grant", 32'(last_grant), 32'd1);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);

        // A reads addr 0
        rd0 = rd_cnt; wr0 = wr_cnt; b0 = b_ack_cnt;
        xfer(1'b0, 1'b0, 16'd0, 16'd0, rd, er, lat);
        check("a_rd0_lat", 32'(lat), 32'd3);
        check("a_rd0_data", 32'(rd), 32'h0807);
        check("a_rd0_err", 32'(er), 32'd0);
        check("a_rd0_rdcyc", 32'(rd_cnt - rd0), 32'd1);
        check("a_rd0_wrcyc", 32'(wr_cnt - wr0), 32'd0);
        check("a_rd0_no_back", 32'(b_ack_cnt - b0), 32'd0);
        check("a_rd0_lastg", 32'(last_grant), 32'd0);

        // B writes 0xBEEF to 20, A reads it back
        rd0 = rd_cnt; wr0 = wr_cnt;
        xfer(1'b1, 1'b1, 16'd20, 16'hBEEF, rd, er, lat);
        check("b_wr_lat", 32'(lat), 32'd3);
        check("b_wr_rdata", 32'(rd), 32'd0);
        check("b_wr_wrcyc", 32'(wr_cnt - wr0), 32'd1);
        check("b_wr_rdcyc", 32'(rd_cnt - rd0), 32'd0);
        check("b_wr_mem", 32'({mem[21], mem[20]}), 32'hBEEF);
        check("b_wr_lastg", 32'(last_grant), 32'd1);
        xfer(1'b0, 1'b0, 16'd20, 16'd0, rd, er, lat);
        check("a_rd20_data", 32'(rd), 32'hBEEF);

        // Contention from reset: A first, then strict alternation while both held
        pulse_reset();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'd20;
        @(posedge clk); #1;
        check("cont_first_lastg", 32'(last_grant), 32'd0);
        check("cont_first_addr", 32'(mem_addr), 32'd0);
        check("cont_first_busy", 32'(busy), 32'd1);
        nack = 0;
        for (int i = 0; i < 40 && nack < 4; i++) begin
            @(posedge clk); #1;
            if (a_ack && b_ack) check("cont_dual_ack", 32'd1, 32'd0);
            if (a_ack) begin ord[nack] = 1'b0; odat[nack] = a_rdata; nack++; end
            else if (b_ack) begin ord[nack] = 1'b1; odat[nack] = b_rdata; nack++; end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("cont_nack", 32'(nack), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < nack) begin
                check($sformatf("cont_order%0d", k), 32'(ord[k]), 32'(k % 2));
                check($sformatf("cont_data%0d", k), 32'(odat[k]),
                      (k % 2 == 0) ? 32'h0807 : 32'hBEEF);
            end
        end
        @(posedge clk); #1;
        check("cont_idle", 32'(busy), 32'd0);

        // Reset during ACCESS of a B write to addr 4
        b0 = b_ack_cnt;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'd4; b_wdata = 16'h1234;
        @(posedge clk); #1;
        check("abort_wr_high", 32'(mem_wr), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_wr_drop", 32'(mem_wr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk); b_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0;
        check("abort_no_back", 32'(b_ack_cnt - b0), 32'd0);
        check("abort_mem", 32'({mem[5], mem[4]}), 32'h000B);
        xfer(1'b0, 1'b0, 16'd4, 16'd0, rd, er, lat);
        check("abort_readback", 32'(rd), 32'h000B);

        // Odd address read
        rd0 = rd_cnt;
        xfer(1'b0, 1'b0, 16'd17, 16'd0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        check("odd_lat", 32'(lat), 32'd2);
        check("odd_data", 32'(rd), 32'd0);
        check("odd_err", 32'(er), 32'd1);
        check("odd_rdcyc", 32'(rd_cnt - rd0), 32'd0);
`else
        check("odd_lat", 32'(lat), 32'd3);
        check("odd_data", 32'(rd), 32'h2007);
        check("odd_err", 32'(er), 32'd0);
        check("odd_rdcyc", 32'(rd_cnt - rd0), 32'd1);
`endif

        check("rd_wr_overlap", 32'(overlap_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
